tc_psum_ctrl: RTL

- Partial-sum controller wrapped around tc_mergetree.
- Holds an N_ENTRY register file of N_MERGE-lane partial sums and drives the merge tree's in_psum in the issue cycle.
- Captures the merge tree's out MT_LAT cycles later and writes it back to the file; on the last K-step it pushes the result to an output FIFO with valid/ready.
- Sits between the tile sequencer (upstream) and the result writer (downstream).

---
 rtl/tc_pkg.sv | 19 +
 rtl/tc_psum_fifo.sv | 74 +++++++
 rtl/tc_psum_ctrl.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/tc_pkg.sv
// Shared sizing and pipeline-stage payload for the tensor-core partial-sum controller.
package tc_pkg;

    localparam int unsigned N_MERGE_DEF   = 16;
    localparam int unsigned DW_DATA_DEF   = 32;
    localparam int unsigned N_ENTRY_DEF   = 8;
    localparam int unsigned MT_LAT_DEF    = 3;
    localparam int unsigned OUT_DEPTH_DEF = 4;

    localparam int unsigned IDX_W = $clog2(N_ENTRY_DEF);

    // One tracking-pipeline slot, shadowing a K-step inside the merge tree.
    typedef struct packed {
        logic             v;
        logic [IDX_W-1:0] idx;
        logic             last;
    } stage_t;

endpackage

// File: rtl/tc_psum_fifo.sv
// Synchronous result FIFO holding {data, idx}; occupancy is exported for credit checks.
module tc_psum_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned DW    = 512,
    parameter int unsigned IW    = 3,
    localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push_i,
    input  logic [DW-1:0] push_data_i,
    input  logic [IW-1:0] push_idx_i,
    input  logic          pop_i,
    output logic          valid_o,
    output logic [DW-1:0] data_o,
    output logic [IW-1:0] idx_o,
    output logic [CW-1:0] count_o
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DW-1:0] data_mem_q [DEPTH];
    logic [IW-1:0] idx_mem_q  [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    // Pointer/count next-state; pushes beyond capacity are dropped defensively.
    always_comb begin
        do_push  = push_i && (count_q != CW'(DEPTH));
        do_pop   = pop_i && (count_q != '0);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                data_mem_q[i] <= '0;
                idx_mem_q[i]  <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (do_push) begin
                data_mem_q[wr_ptr_q] <= push_data_i;
                idx_mem_q[wr_ptr_q]  <= push_idx_i;
            end
        end
    end

    assign valid_o = (count_q != '0);
    assign data_o  = data_mem_q[rd_ptr_q];
    assign idx_o   = idx_mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/tc_psum_ctrl.sv
// Partial-sum controller around tc_mergetree: psum file, writeback tracking, RAW/credit stall, result FIFO.
// Optional macro TC_PSUM_ERRCHK_EN adds per-entry live bits and the err_sticky output.
module tc_psum_ctrl
    import tc_pkg::*;
#(
    parameter int unsigned N_MERGE   = N_MERGE_DEF,
    parameter int unsigned DW_DATA   = DW_DATA_DEF,
    parameter int unsigned MT_LAT    = MT_LAT_DEF,
    parameter int unsigned OUT_DEPTH = OUT_DEPTH_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       issue_valid,
    output logic                       issue_ready,
    input  logic [IDX_W-1:0]           issue_idx,
    input  logic                       issue_first,
    input  logic                       issue_last,
    output logic [N_MERGE*DW_DATA-1:0] mt_psum,
    input  logic [N_MERGE*DW_DATA-1:0] mt_out,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [N_MERGE*DW_DATA-1:0] res_data,
    output logic [IDX_W-1:0]           res_idx
`ifdef TC_PSUM_ERRCHK_EN
    ,
    output logic                       err_sticky
`endif
);

    localparam int unsigned N_ENTRY = N_ENTRY_DEF;
    localparam int unsigned LW      = N_MERGE * DW_DATA;
    localparam int unsigned CNT_W   = $clog2(OUT_DEPTH + 1);
    localparam int unsigned CRD_W   = $clog2(OUT_DEPTH + MT_LAT + 1);

    logic [LW-1:0]    file_q [N_ENTRY];
    stage_t           stage_q [MT_LAT];
    stage_t           stage_d [MT_LAT];
    stage_t           wb;
    logic [CNT_W-1:0] fifo_count;
    logic [CRD_W-1:0] inflight_last;
    logic             idx_busy;
    logic             hazard;
    logic             credit_ok;
    logic             issue_fire;
    logic             push;

    // Stall on RAW against any in-flight K-step of the same entry, or on missing output credit.
    always_comb begin
        idx_busy      = 1'b0;
        inflight_last = '0;
        for (int i = 0; i < int'(MT_LAT); i++) begin
            if (stage_q[i].v && (stage_q[i].idx == issue_idx)) begin
                idx_busy = 1'b1;
            end
            if (stage_q[i].v && stage_q[i].last) begin
                inflight_last = inflight_last + CRD_W'(1);
            end
        end
        hazard      = idx_busy && !issue_first;
        credit_ok   = !issue_last ||
                      ((CRD_W'(fifo_count) + inflight_last) < CRD_W'(OUT_DEPTH));
        issue_ready = !reset && !hazard && credit_ok;
    end

    assign issue_fire = issue_valid && issue_ready;
    assign mt_psum    = (issue_valid && !issue_first) ? file_q[issue_idx] : '0;

    always_comb begin
        stage_d[0].v    = issue_fire;
        stage_d[0].idx  = issue_idx;
        stage_d[0].last = issue_last;
        for (int i = 1; i < int'(MT_LAT); i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(MT_LAT); i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q <= stage_d;
        end
    end

    assign wb   = stage_q[MT_LAT-1];
    assign push = wb.v && wb.last;

    // The last writeback retires the entry so the next tile starts from a clean slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int e = 0; e < int'(N_ENTRY); e++) begin
                file_q[e] <= '0;
            end
        end else if (wb.v) begin
            file_q[wb.idx] <= wb.last ? '0 : mt_out;
        end
    end

    tc_psum_fifo #(
        .DEPTH (OUT_DEPTH),
        .DW    (LW),
        .IW    (IDX_W)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (push),
        .push_data_i (mt_out),
        .push_idx_i  (wb.idx),
        .pop_i       (res_ready),
        .valid_o     (res_valid),
        .data_o      (res_data),
        .idx_o       (res_idx),
        .count_o     (fifo_count)
    );

`ifdef TC_PSUM_ERRCHK_EN
    logic               first_q [MT_LAT];
    logic [N_ENTRY-1:0] live_q;
    logic               err_q;
    logic               err_set;

    // Flag accumulation into a never-started entry, or restarting one still open.
    always_comb begin
        err_set = issue_fire &&
                  ((!issue_first && !live_q[issue_idx] && !idx_busy) ||
                   (issue_first && live_q[issue_idx]));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(MT_LAT); i++) begin
                first_q[i] <= 1'b0;
            end
            live_q <= '0;
            err_q  <= 1'b0;
        end else begin
            first_q[0] <= issue_fire && issue_first;
            for (int i = 1; i < int'(MT_LAT); i++) begin
                first_q[i] <= first_q[i-1];
            end
            if (wb.v) begin
                if (wb.last) begin
                    live_q[wb.idx] <= 1'b0;
                end else if (first_q[MT_LAT-1]) begin
                    live_q[wb.idx] <= 1'b1;
                end
            end
            if (err_set) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err_sticky = err_q;
`endif

endmodule
